// File: rtl/pad_bank.sv
// Register-controlled bidirectional pad bank: per-pin peripheral/GPIO muxing,
// input synchronisation, glitch filtering and edge interrupts behind a zero-wait APB port.
module pad_bank #(
   parameter int N_PINS      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [7:0]        paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   input  logic [N_PINS-1:0] pad_i,
   output logic [N_PINS-1:0] pad_o,
   output logic [N_PINS-1:0] pad_t,
   input  logic [N_PINS-1:0] per_o,
   input  logic [N_PINS-1:0] per_t,
   output logic [N_PINS-1:0] per_i,
   output logic              irq
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

   logic [N_PINS-1:0] mode, dir, out_reg, rise_en, fall_en, status;
   logic [N_PINS-1:0] filt, s, upd, set_bits, wdata, rdata, gpio;
   logic [N_PINS-1:0] sync_ff [SYNC_STAGES];
   logic [CW-1:0]     cnt [N_PINS];
   logic              access, addr_ok, wr, unused_pwdata;

   assign access        = psel & penable;
   assign addr_ok       = (paddr[1:0] == 2'b00) && (paddr <= 8'h18);
   assign pslverr       = access & ~addr_ok;
   assign wr            = access & pwrite & addr_ok;
   assign pready        = 1'b1;
   assign wdata         = pwdata[N_PINS-1:0];
   assign unused_pwdata = ^pwdata;
   assign per_i         = pad_i;

   // Reset forces the peripheral path so boot peripherals work before software runs
   assign gpio  = reset ? '0 : mode;
   assign pad_o = (gpio & out_reg) | (~gpio & per_o);
   assign pad_t = (gpio & ~dir)    | (~gpio & per_t);

   always_ff @(posedge clk) begin
      if (reset) begin
         mode    <= '0;
         dir     <= '0;
         out_reg <= '0;
         rise_en <= '0;
         fall_en <= '0;
      end else if (wr) begin
         case (paddr)
            8'h00:   mode    <= wdata;
            8'h04:   dir     <= wdata;
            8'h08:   out_reg <= wdata;
            8'h10:   rise_en <= wdata;
            8'h14:   fall_en <= wdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata  = '0;
      prdata = '0;
      case (paddr)
         8'h00:   rdata = mode;
         8'h04:   rdata = dir;
         8'h08:   rdata = out_reg;
         8'h0C:   rdata = filt;
         8'h10:   rdata = rise_en;
         8'h14:   rdata = fall_en;
         8'h18:   rdata = status;
         default: rdata = '0;
      endcase
      if (access && !pwrite && addr_ok)
         prdata[N_PINS-1:0] = rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++)
            sync_ff[k] <= '0;
      end else begin
         sync_ff[0] <= pad_i;
         for (int k = 1; k < SYNC_STAGES; k++)
            sync_ff[k] <= sync_ff[k-1];
      end
   end

   assign s = sync_ff[SYNC_STAGES-1];

   // A pin's filtered value only moves after FILTER_LEN consecutive disagreeing samples
   always_comb begin
      upd = '0;
      for (int i = 0; i < N_PINS; i++)
         upd[i] = (s[i] != filt[i]) && (cnt[i] == CNT_MAX);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         filt <= '0;
         for (int i = 0; i < N_PINS; i++)
            cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_PINS; i++) begin
            if (s[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               filt[i] <= s[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   assign set_bits = upd & ((s & rise_en) | (~s & fall_en));

   // A new edge event beats a simultaneous write-1-to-clear of the same bit
   always_ff @(posedge clk) begin
      if (reset)
         status <= '0;
      else if (wr && paddr == 8'h18)
         status <= (status & ~wdata) | set_bits;
      else
         status <= status | set_bits;
   end

   assign irq = |status;

endmodule

// File: tb/tb_pad_bank.sv
// Self-checking bench for pad_bank: directed vectors and corner sequences, then
// randomized pad activity checked against a sliding-window reference model.
module tb_pad_bank;

   localparam int SYNC = 2;
   localparam int FL   = 4;

   logic        clk, reset;
   logic        psel_a, psel_b, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;

   logic [31:0] prdata_a;
   logic        pready_a, pslverr_a, irq_a;
   logic [7:0]  pad_i_a, pad_o_a, pad_t_a, per_o_a, per_t_a, per_i_a;

   logic [31:0] prdata_b;
   logic        pready_b, pslverr_b, irq_b;
   logic [2:0]  pad_i_b, pad_o_b, pad_t_b, per_i_b;

   int tests, fails;

   pad_bank #(.N_PINS(8), .SYNC_STAGES(SYNC), .FILTER_LEN(FL)) dut_a (
      .clk(clk), .reset(reset), .psel(psel_a), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a),
      .pslverr(pslverr_a), .pad_i(pad_i_a), .pad_o(pad_o_a), .pad_t(pad_t_a),
      .per_o(per_o_a), .per_t(per_t_a), .per_i(per_i_a), .irq(irq_a)
   );

   pad_bank #(.N_PINS(3), .SYNC_STAGES(2), .FILTER_LEN(1)) dut_b (
      .clk(clk), .reset(reset), .psel(psel_b), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b),
      .pslverr(pslverr_b), .pad_i(pad_i_b), .pad_o(pad_o_b), .pad_t(pad_t_b),
      .per_o(3'b000), .per_t(3'b111), .per_i(per_i_b), .irq(irq_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apb_write(input bit sel_b, input logic [7:0] a, input logic [31:0] d,
                            output logic err);
      @(negedge clk);
      psel_a = !sel_b; psel_b = sel_b; penable = 0; pwrite = 1; paddr = a; pwdata = d;
      @(negedge clk);
      penable = 1;
      #1 err = sel_b ? pslverr_b : pslverr_a;
      @(posedge clk);
      #1 psel_a = 0; psel_b = 0; penable = 0; pwrite = 0;
   endtask

   // Access-phase read inside the low clock phase; prdata is combinational
   task automatic apb_read(input bit sel_b, input logic [7:0] a, output logic [31:0] d,
                           output logic err);
      psel_a = !sel_b; psel_b = sel_b; penable = 1; pwrite = 0; paddr = a;
      #1 d = sel_b ? prdata_b : prdata_a;
      err = sel_b ? pslverr_b : pslverr_a;
      psel_a = 0; psel_b = 0; penable = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   // Reference model: filter input at edge j is the pad value sampled SYNC edges earlier;
   // a pin flips when the last FL filter inputs all agree on the opposite value.
   logic [7:0] padh [0:2047];
   int         ne;
   logic [7:0] mfilt, mstat, mrise, mfall;

   function automatic logic d_at(int j, int pin);
      if (j - SYNC >= 1) return padh[j-SYNC][pin];
      return 1'b0;
   endfunction

   task automatic model_edge(input logic [7:0] pad, input logic [7:0] w1c);
      logic [7:0] set;
      logic v, same;
      set = '0;
      ne++;
      padh[ne] = pad;
      for (int p = 0; p < 8; p++) begin
         v = d_at(ne, p);
         same = 1'b1;
         for (int j = ne - FL + 1; j <= ne; j++)
            if (d_at(j, p) != v) same = 1'b0;
         if (same && v != mfilt[p]) begin
            mfilt[p] = v;
            if ((v && mrise[p]) || (!v && mfall[p])) set[p] = 1'b1;
         end
      end
      mstat = (mstat & ~w1c) | set;
   endtask

   typedef struct {
      logic [7:0] mode, dir, out, per_o, per_t, exp_pad_o, exp_pad_t;
   } mux_vec_t;

   typedef struct {
      logic [7:0] addr;
      logic       exp_err;
   } err_vec_t;

   mux_vec_t    mux_tab [5];
   err_vec_t    err_tab [7];
   logic [31:0] rd;
   logic        err;
   logic [7:0]  md, dr, ot, pad, w1c;

   initial begin
      mux_tab[0] = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h0F, 8'hA5, 8'h0F};
      mux_tab[1] = '{8'h01, 8'h01, 8'h01, 8'hA5, 8'h0F, 8'hA5, 8'h0E};
      mux_tab[2] = '{8'hF0, 8'h30, 8'hC0, 8'h0F, 8'h00, 8'hCF, 8'hC0};
      mux_tab[3] = '{8'hFF, 8'hAA, 8'h55, 8'h00, 8'hFF, 8'h55, 8'h55};
      mux_tab[4] = '{8'h0F, 8'h00, 8'h0F, 8'hF0, 8'h3C, 8'hFF, 8'h3F};
      err_tab[0] = '{8'h1C, 1'b1};
      err_tab[1] = '{8'h05, 1'b1};
      err_tab[2] = '{8'h02, 1'b1};
      err_tab[3] = '{8'hFF, 1'b1};
      err_tab[4] = '{8'h18, 1'b0};
      err_tab[5] = '{8'h0C, 1'b0};
      err_tab[6] = '{8'h00, 1'b0};

      tests = 0; fails = 0;
      psel_a = 0; psel_b = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
      reset = 1; pad_i_a = 8'hFF; per_o_a = 8'hA5; per_t_a = 8'h0F; pad_i_b = 3'b000;
      for (int i = 0; i < 2048; i++) padh[i] = '0;

      // Reset release with pads high: IN rises exactly SYNC+FL edges later
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset_pad_o", pad_o_a, 8'hA5);
      check_output("reset_pad_t", pad_t_a, 8'h0F);
      check_output("reset_irq", irq_a, 0);
      check_output("pready", pready_a, 1);
      reset = 0;
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk);
         @(negedge clk);
         apb_read(0, 8'h0C, rd, err);
         check_output($sformatf("release_in_c%0d", c), rd, (c >= 6) ? 32'hFF : 32'h00);
      end
      apb_read(0, 8'h18, rd, err);
      check_output("release_status", rd, 0);
      check_output("release_irq", irq_a, 0);

      // Rising-edge interrupt latency
      pad_i_a = 8'h00;
      do_reset();
      repeat (8) @(posedge clk);
      apb_write(0, 8'h10, 32'h02, err);
      @(negedge clk);
      pad_i_a = 8'h02;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 5) begin
            apb_read(0, 8'h18, rd, err);
            check_output("rise_status_e5", rd, 0);
            check_output("rise_irq_e5", irq_a, 0);
         end
      end
      apb_read(0, 8'h18, rd, err);
      check_output("rise_status_e6", rd, 32'h02);
      check_output("rise_irq_e6", irq_a, 1);
      apb_read(0, 8'h0C, rd, err);
      check_output("rise_in_e6", rd, 32'h02);

      pad_i_a = 8'h00;
      repeat (8) @(negedge clk);
      apb_write(0, 8'h18, 32'h02, err);
      @(negedge clk);
      apb_read(0, 8'h18, rd, err);
      check_output("w1c_status", rd, 0);
      check_output("w1c_irq", irq_a, 0);

      // Three-cycle glitch must never reach IN or STATUS
      pad_i_a = 8'h02;
      repeat (3) @(negedge clk);
      pad_i_a = 8'h00;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         apb_read(0, 8'h0C, rd, err);
         check_output($sformatf("glitch_in_%0d", k), rd, 0);
      end
      apb_read(0, 8'h18, rd, err);
      check_output("glitch_status", rd, 0);

      // Falling edge sets STATUS[2]; W1C on the same edge as a new set loses
      apb_write(0, 8'h14, 32'h04, err);
      @(negedge clk);
      pad_i_a = 8'h04;
      repeat (8) @(negedge clk);
      apb_read(0, 8'h18, rd, err);
      check_output("fall_rise_noirq", rd, 0);
      pad_i_a = 8'h00;
      repeat (7) @(negedge clk);
      apb_read(0, 8'h18, rd, err);
      check_output("fall_status", rd, 32'h04);
      pad_i_a = 8'h04;
      repeat (8) @(negedge clk);
      pad_i_a = 8'h00;
      repeat (4) @(posedge clk);
      @(negedge clk);
      psel_a = 1; penable = 0; pwrite = 1; paddr = 8'h18; pwdata = 32'h04;
      @(posedge clk);
      @(negedge clk);
      penable = 1;
      @(posedge clk);
      @(negedge clk);
      psel_a = 0; penable = 0; pwrite = 0;
      apb_read(0, 8'h18, rd, err);
      check_output("collide_status", rd, 32'h04);
      apb_read(0, 8'h0C, rd, err);
      check_output("collide_in", rd, 0);
      apb_write(0, 8'h18, 32'h04, err);
      @(negedge clk);
      apb_read(0, 8'h18, rd, err);
      check_output("clear_status", rd, 0);
      check_output("clear_irq", irq_a, 0);

      // Pad muxing table
      for (int i = 0; i < 5; i++) begin
         per_o_a = mux_tab[i].per_o;
         per_t_a = mux_tab[i].per_t;
         apb_write(0, 8'h00, {24'hFFFFFF, mux_tab[i].mode}, err);
         apb_write(0, 8'h04, {24'h0, mux_tab[i].dir}, err);
         apb_write(0, 8'h08, {24'h0, mux_tab[i].out}, err);
         @(negedge clk);
         check_output($sformatf("mux%0d_pad_o", i), pad_o_a, mux_tab[i].exp_pad_o);
         check_output($sformatf("mux%0d_pad_t", i), pad_t_a, mux_tab[i].exp_pad_t);
         apb_read(0, 8'h00, rd, err);
         check_output($sformatf("mux%0d_mode_rd", i), rd, {24'h0, mux_tab[i].mode});
      end

      // Error handling: bad writes change nothing, bad reads give 0
      apb_write(0, 8'h10, 32'h33, err);
      apb_write(0, 8'h14, 32'h0C, err);
      apb_write(0, 8'h1C, 32'hFFFFFFFF, err);
      check_output("wr1c_err", err, 1);
      apb_write(0, 8'h01, 32'hFFFFFFFF, err);
      check_output("wr01_err", err, 1);
      apb_write(0, 8'h0C, 32'hFFFFFFFF, err);
      check_output("wr0c_err", err, 0);
      @(negedge clk);
      apb_read(0, 8'h00, rd, err); check_output("keep_mode", rd, 32'h0F);
      apb_read(0, 8'h04, rd, err); check_output("keep_dir", rd, 32'h00);
      apb_read(0, 8'h08, rd, err); check_output("keep_out", rd, 32'h0F);
      apb_read(0, 8'h10, rd, err); check_output("keep_rise", rd, 32'h33);
      apb_read(0, 8'h14, rd, err); check_output("keep_fall", rd, 32'h0C);
      apb_read(0, 8'h0C, rd, err); check_output("keep_in", rd, 32'h00);
      for (int i = 0; i < 7; i++) begin
         apb_read(0, err_tab[i].addr, rd, err);
         check_output($sformatf("rd%0h_err", err_tab[i].addr), err, err_tab[i].exp_err);
         if (err_tab[i].exp_err)
            check_output($sformatf("rd%0h_data", err_tab[i].addr), rd, 0);
      end

      // Narrow instance, no filtering
      apb_write(1, 8'h00, 32'hFF, err);
      @(negedge clk);
      apb_read(1, 8'h00, rd, err);
      check_output("small_mode_rd", rd, 32'h07);
      pad_i_b = 3'b101;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         apb_read(1, 8'h0C, rd, err);
         check_output($sformatf("small_in_e%0d", k), rd, (k == 3) ? 32'h5 : 32'h0);
      end

      // Randomized activity against the reference model
      pad_i_a = 8'h00;
      do_reset();
      md = 8'($urandom); dr = 8'($urandom); ot = 8'($urandom);
      mrise = 8'($urandom); mfall = 8'($urandom);
      mfilt = '0; mstat = '0; ne = 0; pad = '0;
      apb_write(0, 8'h00, {24'h0, md}, err);
      apb_write(0, 8'h04, {24'h0, dr}, err);
      apb_write(0, 8'h08, {24'h0, ot}, err);
      apb_write(0, 8'h10, {24'h0, mrise}, err);
      apb_write(0, 8'h14, {24'h0, mfall}, err);
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         apb_read(0, 8'h0C, rd, err);
         check_output("rand_in", rd, {24'h0, mfilt});
         apb_read(0, 8'h18, rd, err);
         check_output("rand_status", rd, {24'h0, mstat});
         check_output("rand_irq", irq_a, |mstat);
         check_output("rand_per_i", per_i_a, pad_i_a);
         check_output("rand_pad_o", pad_o_a, (md & ot) | (~md & per_o_a));
         check_output("rand_pad_t", pad_t_a, (md & ~dr) | (~md & per_t_a));
         for (int p = 0; p < 8; p++)
            if ($urandom_range(0, 5) == 0) pad[p] = ~pad[p];
         pad_i_a = pad;
         per_o_a = 8'($urandom);
         per_t_a = 8'($urandom);
         w1c = '0;
         if ($urandom_range(0, 7) == 0) begin
            w1c = 8'($urandom);
            psel_a = 1; penable = 1; pwrite = 1; paddr = 8'h18; pwdata = {24'h0, w1c};
         end
         @(posedge clk);
         model_edge(pad, w1c);
         #1 psel_a = 0; penable = 0; pwrite = 0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pad_bank.md
Name: pad_bank

Overview:
- Parametrised, register-controlled pad bank for the ASIC top level.
- Generalises per-pin bidirectional pad handling to N_PINS channels.
- Each pin is either passed through to its peripheral function or taken over as software GPIO.
- Adds input synchronisation, a glitch filter, and edge-detect interrupts per pin. It sits between the IOBUF pad cells and soc_top peripherals and is programmed over APB.

Parameters:
N_PINS, 8, number of pad channels (1..32)
SYNC_STAGES, 2, input synchroniser depth (>=2)
FILTER_LEN, 4, consecutive stable cycles required before filtered input changes (1..255; 1 = no filtering)

Ports:
clk  in  1  clock (SoC clock domain)
reset  in  1  synchronous, active-high reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  8  APB byte address
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  APB ready
pslverr  out  1  APB error
pad_i  in  N_PINS  from pad cells
pad_o  out  N_PINS  to pad cells
pad_t  out  N_PINS  pad tristate; 0 = drive (output), 1 = input
per_o  in  N_PINS  peripheral output data
per_t  in  N_PINS  peripheral tristate (same polarity as pad_t)
per_i  out  N_PINS  to peripheral; equals pad_i, combinational, no latency
irq  out  1  level interrupt

Behaviour:
- Registers are N_PINS wide, bits 0..N_PINS-1. Higher read bits are 0; higher write bits are ignored.
  - 0x00 MODE: 1 = GPIO, 0 = peripheral. Reset 0.
  - 0x04 DIR: 1 = output in GPIO mode. Reset 0.
  - 0x08 OUT: Reset 0.
  - 0x0C IN: read-only, filtered value. Writes ignored, no error.
  - 0x10 RISE_EN: Reset 0.
  - 0x14 FALL_EN: Reset 0.
  - 0x18 STATUS: write-1-to-clear. Reset 0.
- Pad muxing, combinational per pin:
  - pad_o = MODE ? OUT : per_o.
  - pad_t = MODE ? ~DIR : per_t.
  - Under reset, all pins follow the peripheral path, so the UART boots without software.
- APB timing:
  - Zero wait state: pready = 1 at all times.
  - Write commits on the clk edge where psel & penable & pwrite.
  - prdata is valid while psel & penable & ~pwrite, and 0 otherwise.
- APB errors:
  - Unmapped or unaligned paddr (paddr[1:0] != 0 or > 0x18): pslverr = 1 during the access phase.
  - On an error, writes are ignored and reads return 0. pslverr is 0 otherwise.
- Input path per pin:
  - pad_i passes through a SYNC_STAGES flop chain to give s; chain reset value 0.
  - Filter state: filt (reset 0) and counter cnt (reset 0, width clog2(FILTER_LEN+1)).
  - If s == filt: cnt <= 0.
  - Else if cnt == FILTER_LEN-1: filt <= s, cnt <= 0; this edge is the "update".
  - Else: cnt <= cnt+1.
  - Any single-cycle mismatch shorter than FILTER_LEN cycles resets the count and never reaches filt.
  - Latency from a pad change to IN changing: SYNC_STAGES + FILTER_LEN clk edges.
- Edge detect and status:
  - On the update edge, STATUS[i] <= 1 if (s==1 & RISE_EN[i]) or (s==0 & FALL_EN[i]).
  - The set is in the same edge as filt changes.
  - A set and a W1C of the same bit in the same cycle: set wins, bit stays 1.
  - Disabling an enable does not clear already-set STATUS.
- irq: combinational OR of STATUS bits 0..N_PINS-1. Reset 0.
- GPIO readback: IN reflects the pad even when the pin is a GPIO output (loopback through the pad).
- Reset mid-operation:
  - All registers, sync chains, filt, cnt and STATUS clear on the next clk edge.
  - Because filt is 0 and RISE_EN is 0, a pad held high during release produces no interrupt.
  - Its IN becomes 1 after SYNC_STAGES + FILTER_LEN cycles.

Test Plan:
- Reset release, pad_i=0xFF, per_o=0xA5, per_t=0x0F -> pad_o=0xA5, pad_t=0x0F, irq=0; IN reads 0x00 until exactly cycle 6 after release, then 0xFF; STATUS=0.
- Write MODE=0x01, DIR=0x01, OUT=0x01 -> pad_o[0]=1, pad_t[0]=0; pins 1..7 still follow per_o/per_t; readback of MODE=0x01.
- RISE_EN=0x02; pad_i[1] 0->1 held -> STATUS=0x02 and irq=1 exactly 6 edges after the change. A 3-cycle glitch on pad_i[1] instead -> IN and STATUS unchanged.
- FALL_EN=0x04, STATUS bit 2 set; W1C 0x04 on the same edge as a new fall update -> STATUS[2] stays 1; a later W1C 0x04 -> STATUS=0, irq=0.
- Read paddr 0x1C and 0x05 -> pslverr=1, prdata=0; write 0xFFFFFFFF to 0x1C -> no register changes; write 0x0C -> pslverr=0, IN unaffected.
- N_PINS=3, FILTER_LEN=1: write MODE=0xFF -> reads 0x07; pad change visible in IN after exactly 3 edges.
